// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the PRBS checker and generator.
// State encodings and polynomial taps live here so both sides agree.
package prbs_checker_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_e;

   localparam int PRBS7_N    = 7;
   localparam int PRBS7_TAP  = 6;
   localparam int PRBS15_N   = 15;
   localparam int PRBS15_TAP = 14;
   localparam int PRBS23_N   = 23;
   localparam int PRBS23_TAP = 18;
   localparam int PRBS31_N   = 31;
   localparam int PRBS31_TAP = 28;

endpackage

// File: rtl/prbs_checker_saturating_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment; the count sticks at all-ones.
module saturating_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // next count: clear wins, otherwise increment unless saturated
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   // count register with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker.
// Fills an LFSR from the stream, verifies it, then flywheels and counts errors.
module prbs_checker
   import prbs_checker_pkg::*;
#(
   parameter int N              = PRBS7_N,
   parameter int TAPA           = PRBS7_TAP,
   parameter int LOCK_COUNT     = 64,
   parameter int WINDOW         = 128,
   parameter int LOSS_THRESHOLD = 16,
   parameter int COUNT_WIDTH    = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_bit,
   input  logic                   in_valid,
   input  logic                   clear_counters,
   output logic [1:0]             state,
   output logic                   locked,
   output logic                   error_pulse,
   output logic [COUNT_WIDTH-1:0] error_count,
   output logic [COUNT_WIDTH-1:0] bit_count,
   output logic [15:0]            loss_count
);

   localparam int FW = $clog2(N + 1);

   state_e        state_q, state_d;
   logic [N-1:0]  h_q, h_d;
   logic [FW-1:0] fill_q, fill_d;
   logic [15:0]   run_q, run_d;
   logic [15:0]   wcnt_q, wcnt_d;
   logic [15:0]   werr_q, werr_d;
   logic          locked_q, locked_d;
   logic          pulse_q, pulse_d;
   logic          inc_err, inc_bit, inc_loss;
   logic          pred;
   logic [N-1:0]  h_rx;

   // prediction uses the history before this bit is shifted in
   assign pred = h_q[TAPA-1] ^ h_q[N-1];
   assign h_rx = {h_q[N-2:0], in_bit};

   // next-state logic for search, verify and flywheel phases
   always_comb begin
      state_d  = state_q;
      h_d      = h_q;
      fill_d   = fill_q;
      run_d    = run_q;
      wcnt_d   = wcnt_q;
      werr_d   = werr_q;
      pulse_d  = 1'b0;
      inc_err  = 1'b0;
      inc_bit  = 1'b0;
      inc_loss = 1'b0;
      if (in_valid) begin
         unique case (state_q)
            SEARCH: begin
               h_d    = h_rx;
               fill_d = fill_q + FW'(1);
               if (fill_d == FW'(N)) begin
                  state_d = VERIFY;
                  run_d   = '0;
                  fill_d  = '0;
               end
            end
            VERIFY: begin
               h_d = h_rx;
               // an all-zero history is the stuck-at-0 trap
               if ((in_bit != pred) || (h_rx == '0)) begin
                  state_d = SEARCH;
                  fill_d  = '0;
               end else begin
                  run_d = run_q + 16'd1;
                  if (run_d == 16'(LOCK_COUNT)) begin
                     state_d = LOCKED;
                     wcnt_d  = '0;
                     werr_d  = '0;
                  end
               end
            end
            LOCKED: begin
               // flywheel: feed back the prediction, not the data
               h_d     = {h_q[N-2:0], pred};
               inc_bit = 1'b1;
               wcnt_d  = wcnt_q + 16'd1;
               if (in_bit != pred) begin
                  inc_err = 1'b1;
                  pulse_d = 1'b1;
                  werr_d  = werr_q + 16'd1;
               end
               if (werr_d == 16'(LOSS_THRESHOLD)) begin
                  state_d  = SEARCH;
                  fill_d   = '0;
                  inc_loss = 1'b1;
                  wcnt_d   = '0;
                  werr_d   = '0;
               end else if (wcnt_d == 16'(WINDOW)) begin
                  wcnt_d = '0;
                  werr_d = '0;
               end
            end
            default: begin
               state_d = SEARCH;
               fill_d  = '0;
            end
         endcase
      end
      locked_d = (state_d == LOCKED);
   end

   // checker state registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= SEARCH;
         h_q      <= '0;
         fill_q   <= '0;
         run_q    <= '0;
         wcnt_q   <= '0;
         werr_q   <= '0;
         locked_q <= 1'b0;
         pulse_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         h_q      <= h_d;
         fill_q   <= fill_d;
         run_q    <= run_d;
         wcnt_q   <= wcnt_d;
         werr_q   <= werr_d;
         locked_q <= locked_d;
         pulse_q  <= pulse_d;
      end
   end

   saturating_counter #(.WIDTH(COUNT_WIDTH)) u_err_cnt (
      .clock (clock),
      .reset (reset),
      .clear (clear_counters),
      .inc   (inc_err),
      .count (error_count)
   );

   saturating_counter #(.WIDTH(COUNT_WIDTH)) u_bit_cnt (
      .clock (clock),
      .reset (reset),
      .clear (clear_counters),
      .inc   (inc_bit),
      .count (bit_count)
   );

   saturating_counter #(.WIDTH(16)) u_loss_cnt (
      .clock (clock),
      .reset (reset),
      .clear (clear_counters),
      .inc   (inc_loss),
      .count (loss_count)
   );

   assign state       = state_q;
   assign locked      = locked_q;
   assign error_pulse = pulse_q;

endmodule
